// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared defaults and pointer/count types for the byte FIFO.
package sync_fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;
    localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

    typedef logic [ADDR_W_DEF-1:0] ptr_t;
    typedef logic [ADDR_W_DEF:0]   cnt_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - DEPTH x DATA_W storage, synchronous write, registered read.
module sync_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read-before-write: a read and write to the same slot return the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock byte FIFO with registered read data and flags.
// SYNC_FIFO_COUNT_EN exposes the occupancy register as fifo_count.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] fifo_din,
    input  logic              write,
    input  logic              read,
    output logic [DATA_W-1:0] fifo_dout,
    output logic              empty,
    output logic              full
`ifdef SYNC_FIFO_COUNT_EN
    ,
    output logic [ADDR_W:0]   fifo_count
`endif
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              wr_acc, rd_acc;

    // A write into a full FIFO is allowed when a read frees a slot at the same edge.
    always_comb begin
        wr_acc   = write & (~full_q | read);
        rd_acc   = read & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == FULL_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    sync_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (fifo_din),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q),
        .rdata_o (fifo_dout)
    );

    assign empty = empty_q;
    assign full  = full_q;

`ifdef SYNC_FIFO_COUNT_EN
    assign fifo_count = count_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed vector bench for sync_fifo.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       write;
    logic       read;
    logic [7:0] fifo_din;
    logic [7:0] fifo_dout;
    logic       empty;
    logic       full;
`ifdef SYNC_FIFO_COUNT_EN
    logic [4:0] fifo_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_din  (fifo_din),
        .write     (write),
        .read      (read),
        .fifo_dout (fifo_dout),
        .empty     (empty),
        .full      (full)
`ifdef SYNC_FIFO_COUNT_EN
        ,
        .fifo_count(fifo_count)
`endif
    );

    typedef struct {
        logic       w;
        logic       r;
        logic [7:0] din;
        logic [7:0] dout;
        logic       emp;
        logic       ful;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        write    = w;
        read     = r;
        fifo_din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'hA1, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 8'hB2, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 8'hC3, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h00, 8'hA1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'h00, 8'hB2, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h00, 8'hC3, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h00, 8'hC3, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 8'h77, 8'hC3, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'h00, 8'h77, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 8'h77, 1'b1, 1'b0};

        rst = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        chk("reset_empty", {7'd0, empty}, 8'h01);
        chk("reset_full", {7'd0, full}, 8'h00);
        chk("reset_dout", fifo_dout, 8'h00);

        for (int i = 0; i < 11; i++) begin
            cyc(vecs[i].w, vecs[i].r, vecs[i].din);
            chk($sformatf("vec%0d_dout", i), fifo_dout, vecs[i].dout);
            chk($sformatf("vec%0d_empty", i), {7'd0, empty}, {7'd0, vecs[i].emp});
            chk($sformatf("vec%0d_full", i), {7'd0, full}, {7'd0, vecs[i].ful});
        end

        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 8'(16 + i));
            chk($sformatf("fill%0d_full", i), {7'd0, full}, (i == 15) ? 8'h01 : 8'h00);
            chk($sformatf("fill%0d_empty", i), {7'd0, empty}, 8'h00);
        end
        cyc(1'b1, 1'b0, 8'hFF);
        chk("drop_full", {7'd0, full}, 8'h01);
        chk("drop_dout", fifo_dout, 8'h77);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk($sformatf("drain%0d_dout", i), fifo_dout, 8'(16 + i));
            chk($sformatf("drain%0d_empty", i), {7'd0, empty}, (i == 15) ? 8'h01 : 8'h00);
            chk($sformatf("drain%0d_full", i), {7'd0, full}, 8'h00);
        end

        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 8'(32 + i));
        end
        cyc(1'b1, 1'b1, 8'h5A);
        chk("rw_full_full", {7'd0, full}, 8'h01);
        chk("rw_full_dout", fifo_dout, 8'h20);
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk($sformatf("rwdrain%0d_dout", i), fifo_dout, 8'(33 + i));
        end
        cyc(1'b0, 1'b1, 8'h00);
        chk("rw_last_dout", fifo_dout, 8'h5A);
        chk("rw_last_empty", {7'd0, empty}, 8'h01);

        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 10; i++) begin
                cyc(1'b1, 1'b0, 8'(64 + rep * 10 + i));
            end
            for (int i = 0; i < 10; i++) begin
                cyc(1'b0, 1'b1, 8'h00);
                chk($sformatf("wrap%0d_%0d_dout", rep, i), fifo_dout, 8'(64 + rep * 10 + i));
            end
        end
        chk("wrap_empty", {7'd0, empty}, 8'h01);

        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 8'(96 + i));
        end
        chk("pre_rst_empty", {7'd0, empty}, 8'h00);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        chk("mid_rst_empty", {7'd0, empty}, 8'h01);
        chk("mid_rst_full", {7'd0, full}, 8'h00);
        chk("mid_rst_dout", fifo_dout, 8'h00);
        cyc(1'b1, 1'b0, 8'hE7);
        chk("post_rst_wr_empty", {7'd0, empty}, 8'h00);
        cyc(1'b0, 1'b1, 8'h00);
        chk("post_rst_rd_dout", fifo_dout, 8'hE7);
        chk("post_rst_rd_empty", {7'd0, empty}, 8'h01);
        cyc(1'b0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
